// File: rtl/ssd_scan_if.sv
// Bus bundle between a display host and the seven-segment scan controller.
// The host loads digit data and controls; the controller drives the segment and digit lines.
interface ssd_scan_if #(
    parameter int unsigned DIGITS = 4
) ();
    logic                  load;
    logic [4*DIGITS-1:0]   digits_in;
    logic [DIGITS-1:0]     dp_in;
    logic                  blank_lz;
    logic [DIGITS-1:0]     blink_mask;
    logic [DIGITS-1:0]     ssd_ctl;
    logic [7:0]            ssd_in;

    modport master (
        output load, digits_in, dp_in, blank_lz, blink_mask,
        input  ssd_ctl, ssd_in
    );

    modport slave (
        input  load, digits_in, dp_in, blank_lz, blink_mask,
        output ssd_ctl, ssd_in
    );
endinterface

// File: rtl/ssd_scan_ctrl.sv
// Multiplexed N-digit common-anode seven-segment controller with frame-synchronous
// double buffering, leading-zero blanking, per-digit blink and on-chip hex decode.
module ssd_scan_ctrl #(
    parameter int unsigned DIGITS       = 4,
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic        clk,
    input  logic        rst,
    ssd_scan_if.slave   bus
);
    localparam int unsigned DW = 4 * DIGITS;
    localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [PW-1:0]     pcnt, pcnt_n;
    logic [IW-1:0]     idx, idx_n;
    logic [FW-1:0]     fcnt, fcnt_n;
    logic              bphase, bphase_n;
    logic              pend_v, pend_v_n;
    logic [DW-1:0]     pend_dig, pend_dig_n;
    logic [DIGITS-1:0] pend_dp, pend_dp_n;
    logic [DW-1:0]     act_dig, act_dig_n;
    logic [DIGITS-1:0] act_dp, act_dp_n;
    logic [DIGITS-1:0] ctl_q, ctl_n;
    logic [7:0]        seg_q, seg_n;

    logic              tick_c;
    logic              idx_last_c;
    logic              frame_c;
    logic [3:0]        cur_nib_c;
    logic              cur_dp_c;
    logic              upper_zero_c;
    logic              lz_blank_c;
    logic              blink_blank_c;

    // Active-low hex decode, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Next-state for prescaler, scan index, blink timer and the two buffers.
    always_comb begin
        pcnt_n     = pcnt;
        idx_n      = idx;
        fcnt_n     = fcnt;
        bphase_n   = bphase;
        pend_v_n   = pend_v;
        pend_dig_n = pend_dig;
        pend_dp_n  = pend_dp;
        act_dig_n  = act_dig;
        act_dp_n   = act_dp;

        tick_c     = (pcnt == PW'(REFRESH_DIV - 1));
        idx_last_c = (idx == IW'(DIGITS - 1));
        frame_c    = tick_c && idx_last_c;

        pcnt_n = tick_c ? '0 : pcnt + PW'(1);

        if (tick_c) begin
            idx_n = idx_last_c ? '0 : idx + IW'(1);
        end

        if (frame_c) begin
            if (fcnt == FW'(BLINK_FRAMES - 1)) begin
                fcnt_n   = '0;
                bphase_n = ~bphase;
            end else begin
                fcnt_n = fcnt + FW'(1);
            end
        end

        // A load on the boundary edge bypasses the pending buffer entirely.
        if (bus.load && frame_c) begin
            act_dig_n = bus.digits_in;
            act_dp_n  = bus.dp_in;
            pend_v_n  = 1'b0;
        end else if (bus.load) begin
            pend_dig_n = bus.digits_in;
            pend_dp_n  = bus.dp_in;
            pend_v_n   = 1'b1;
        end else if (frame_c && pend_v) begin
            act_dig_n = pend_dig;
            act_dp_n  = pend_dp;
            pend_v_n  = 1'b0;
        end
    end

    // Output decode for the digit currently selected by idx.
    always_comb begin
        ctl_n        = '1;
        seg_n        = 8'hFF;
        cur_nib_c    = act_dig[4*int'(idx) +: 4];
        cur_dp_c     = act_dp[int'(idx)];
        upper_zero_c = 1'b1;

        for (int j = 0; j < int'(DIGITS); j++) begin
            if ((j >= int'(idx)) && (act_dig[4*j +: 4] != 4'h0)) begin
                upper_zero_c = 1'b0;
            end
        end

        lz_blank_c    = bus.blank_lz && (idx != '0) && upper_zero_c;
        blink_blank_c = bphase && bus.blink_mask[int'(idx)];

        if (!lz_blank_c && !blink_blank_c) begin
            ctl_n = ~(DIGITS'(1) << idx);
            seg_n = {~cur_dp_c, hex7(cur_nib_c)};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt     <= '0;
            idx      <= '0;
            fcnt     <= '0;
            bphase   <= 1'b0;
            pend_v   <= 1'b0;
            pend_dig <= '0;
            pend_dp  <= '0;
            act_dig  <= '0;
            act_dp   <= '0;
            ctl_q    <= '1;
            seg_q    <= 8'hFF;
        end else begin
            pcnt     <= pcnt_n;
            idx      <= idx_n;
            fcnt     <= fcnt_n;
            bphase   <= bphase_n;
            pend_v   <= pend_v_n;
            pend_dig <= pend_dig_n;
            pend_dp  <= pend_dp_n;
            act_dig  <= act_dig_n;
            act_dp   <= act_dp_n;
            ctl_q    <= ctl_n;
            seg_q    <= seg_n;
        end
    end

    assign bus.ssd_ctl = ctl_q;
    assign bus.ssd_in  = seg_q;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Directed plus randomized bench for ssd_scan_ctrl against a time-based reference model
// (4 digits, 4 cycles per digit, 2 frames per blink half-period).
module tb_ssd_scan_ctrl;
    localparam int D  = 4;
    localparam int RD = 4;
    localparam int BF = 2;
    localparam int FR = D * RD;

    typedef struct {
        int          c;
        logic [15:0] d;
        logic [3:0]  p;
    } load_t;

    logic clk;
    logic rst;

    ssd_scan_if #(.DIGITS(D)) bus ();

    ssd_scan_ctrl #(
        .DIGITS(D),
        .REFRESH_DIV(RD),
        .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    load_t loads [$];
    int    k;
    int    checks;
    int    fails;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s at k=%0d: observed %h expected %h", tag, k, obs, exp);
        end
    endtask

    // Display for edge kk: shows whatever was last loaded before the current frame began.
    function automatic void model(input int kk, output logic [3:0] ectl, output logic [7:0] ein);
        int          di;
        int          fr;
        logic [15:0] data;
        logic [3:0]  dp;
        logic        lz;
        logic        bl;
        di   = (kk / RD) % D;
        fr   = kk / FR;
        data = '0;
        dp   = '0;
        foreach (loads[i]) begin
            if (loads[i].c < fr * FR) begin
                data = loads[i].d;
                dp   = loads[i].p;
            end
        end
        lz = bus.blank_lz && (di > 0) && ((data >> (4 * di)) == 16'h0);
        bl = (((fr / BF) % 2) == 1) && bus.blink_mask[di];
        if (lz || bl) begin
            ectl = 4'hF;
            ein  = 8'hFF;
        end else begin
            ectl = ~(4'b0001 << di);
            ein  = {~dp[di], seg_tab[(data >> (4 * di)) & 16'hF]};
        end
    endfunction

    task automatic step(input logic ld, input logic [15:0] d, input logic [3:0] p);
        logic [3:0] ectl;
        logic [7:0] ein;
        bus.load      = ld;
        bus.digits_in = d;
        bus.dp_in     = p;
        @(posedge clk);
        if (rst) begin
            loads.delete();
            k    = 0;
            ectl = 4'hF;
            ein  = 8'hFF;
        end else begin
            model(k, ectl, ein);
            if (ld) loads.push_back('{c: k, d: d, p: p});
            k++;
        end
        #1;
        bus.load = 1'b0;
        chk("ssd_ctl", 32'(bus.ssd_ctl), 32'(ectl));
        chk("ssd_in", 32'(bus.ssd_in), 32'(ein));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 4'h0);
    endtask

    task automatic idle_until(input int phase);
        int guard;
        guard = 0;
        while ((k % FR) != phase && guard < 4 * FR) begin
            step(1'b0, 16'h0, 4'h0);
            guard++;
        end
    endtask

    initial begin
        logic ld;
        checks         = 0;
        fails          = 0;
        k              = 0;
        rst            = 1'b1;
        bus.load       = 1'b0;
        bus.digits_in  = '0;
        bus.dp_in      = '0;
        bus.blank_lz   = 1'b0;
        bus.blink_mask = '0;

        // Reset, then scan order with 1234.
        idle(3);
        rst = 1'b0;
        step(1'b1, 16'h1234, 4'h0);
        idle(3 * FR);

        // Load 5678 while digit 1 is lit; old value holds for the rest of the frame.
        idle_until(5);
        step(1'b1, 16'h5678, 4'h0);
        chk("pend_v_set", 32'(dut.pend_v), 32'd1);
        idle(2 * FR);

        // Leading-zero blanking.
        bus.blank_lz = 1'b1;
        step(1'b1, 16'h0070, 4'h0);
        idle(2 * FR);
        step(1'b1, 16'h0000, 4'h0);
        idle(2 * FR);
        bus.blank_lz = 1'b0;

        // Blink with dp on digit 0.
        bus.blink_mask = 4'b0001;
        step(1'b1, 16'h4321, 4'b0001);
        idle(6 * FR);
        bus.blink_mask = 4'b0000;

        // Load on the frame-boundary tick lands in the very next digit-0 slot.
        idle_until(FR - 1);
        step(1'b1, 16'h9ABC, 4'b0100);
        chk("pend_v_wrap", 32'(dut.pend_v), 32'd0);
        idle(FR);

        // Reset during digit 2 with a load pending.
        idle_until(8);
        step(1'b1, 16'hDEAD, 4'hF);
        step(1'b0, 16'h0, 4'h0);
        rst = 1'b1;
        step(1'b0, 16'h0, 4'h0);
        rst = 1'b0;
        chk("pend_v_rst", 32'(dut.pend_v), 32'd0);
        idle(2 * FR);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 39) == 0) bus.blank_lz = 1'($urandom);
            if ($urandom_range(0, 39) == 0) bus.blink_mask = 4'($urandom);
            rst = ($urandom_range(0, 199) == 0);
            ld  = ($urandom_range(0, 9) == 0);
            step(ld, 16'($urandom), 4'($urandom));
            rst = 1'b0;
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
